// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU pipeline: opcodes, result flags and small helpers.
// The legacy 2-bit op_code enum is retained unchanged for existing users.
package alu_pipe_pkg;

  typedef enum logic [1:0] {
    OPC_OR  = 2'b00,
    OPC_AND = 2'b01,
    OPC_ADD = 2'b10,
    OPC_SUB = 2'b11
  } op_code;

  // Low four codes are the legacy op_code values zero-extended.
  typedef enum logic [3:0] {
    OP_OR   = 4'b0000,
    OP_AND  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

  // Signed overflow of an addition given the operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Stateless ALU datapath placed between the operand and result registers.
// Shift ops exist only when ALU_PIPE_SHIFT_EN is defined; otherwise they decode as illegal.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_t            i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_result,
  output alu_flags_t         o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // A + ~B + 1: bit WIDTH is set exactly when A >= B unsigned (no borrow).
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);

`ifdef ALU_PIPE_SHIFT_EN
  localparam int unsigned SH_W = $clog2(WIDTH);
  logic [SH_W-1:0] w_shamt;
  assign w_shamt = i_b[SH_W-1:0];
`endif

  always_comb begin
    w_result = '0;
    w_flags  = FLAGS_CLEAR;
    case (i_op)
      OP_OR:   w_result = i_a | i_b;
      OP_AND:  w_result = i_a & i_b;
      OP_XOR:  w_result = i_a ^ i_b;
      OP_NOR:  w_result = ~(i_a | i_b);
      OP_ADD: begin
        w_result      = w_sum[WIDTH-1:0];
        w_flags.carry = w_sum[WIDTH];
        w_flags.ovf   = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1]);
      end
      OP_SUB: begin
        w_result      = w_diff[WIDTH-1:0];
        w_flags.carry = w_diff[WIDTH];
        w_flags.ovf   = add_ovf(i_a[WIDTH-1], ~i_b[WIDTH-1], w_diff[WIDTH-1]);
      end
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_PIPE_SHIFT_EN
      OP_SLL:  w_result = i_a << w_shamt;
      OP_SRL:  w_result = i_a >> w_shamt;
      OP_SRA:  w_result = $signed(i_a) >>> w_shamt;
`endif
      default: w_flags.illegal = 1'b1;
    endcase
    w_flags.zero = (w_result == '0);
  end

  assign o_result = w_result;
  assign o_flags  = w_flags;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds the result.
// Optional shifter ops are enabled by defining ALU_PIPE_SHIFT_EN.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
);

  logic             r_s1_valid;
  alu_op_t          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  alu_flags_t       r_s2_flags;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s2_accept;
  logic             w_s1_accept;
  logic [WIDTH-1:0] w_core_result;
  alu_flags_t       w_core_flags;

  // A stage may load when empty or when its current contents leave this cycle.
  assign w_s2_accept = !r_s2_valid || out_ready;
  assign w_s1_accept = !r_s1_valid || w_s2_accept;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OP_OR;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= FLAGS_CLEAR;
      r_s2_tag    <= '0;
    end else begin
      if (w_s1_accept) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op  <= in_op;
          r_s1_a   <= in_a;
          r_s1_b   <= in_b;
          r_s1_tag <= in_tag;
        end
      end
      if (w_s2_accept) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_core_result;
          r_s2_flags  <= w_core_flags;
          r_s2_tag    <= r_s1_tag;
        end
      end
    end
  end

  // Outputs are forced to their cleared values for the whole time rst is high.
  assign in_ready    = !rst && w_s1_accept;
  assign out_valid   = !rst && r_s2_valid;
  assign out_result  = rst ? '0 : r_s2_result;
  assign out_zero    = !rst && r_s2_flags.zero;
  assign out_carry   = !rst && r_s2_flags.carry;
  assign out_ovf     = !rst && r_s2_flags.ovf;
  assign out_illegal = !rst && r_s2_flags.illegal;
  assign out_tag     = rst ? '0 : r_s2_tag;

endmodule
